// File: rtl/xnor_pop_sequencer_pkg.sv
// Shared definitions for the xnor_popcount control stage.
// Datapath latency lives here so timing changes land in one place.
package xnor_pop_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_SAMPLE,
    S_EMIT,
    S_DONE
  } seq_state_e;

  localparam int DRAIN_CYCLES = 2;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/xnor_pop_sequencer_if.sv
// Memory/datapath control bus and packed result stream
// between the sequencer and its neighbours.
interface xnor_pop_sequencer_if #(
  parameter int K_CHUNKS  = 4,
  parameter int M_NEURONS = 32,
  parameter int PACK_W    = 16
);
  import xnor_pop_sequencer_pkg::*;

  localparam int AAW = clog2_min1(K_CHUNKS);
  localparam int WAW = clog2_min1(M_NEURONS * K_CHUNKS);
  localparam int TAW = clog2_min1(M_NEURONS);

  logic              rd_en;
  logic [AAW-1:0]    act_addr;
  logic [WAW-1:0]    wgt_addr;
  logic [TAW-1:0]    thr_addr;
  logic              acc_clr;
  logic              cmp_in;
  logic [PACK_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output rd_en, act_addr, wgt_addr, thr_addr, acc_clr,
    output out_data, out_valid, out_last,
    input  cmp_in, out_ready
  );

  modport slave (
    input  rd_en, act_addr, wgt_addr, thr_addr, acc_clr,
    input  out_data, out_valid, out_last,
    output cmp_in, out_ready
  );

endinterface

// File: rtl/xnor_pop_sequencer_bit_packer.sv
// Packs threshold bits into PACK_W-bit words and holds each
// finished word on a registered valid/ready output stage.
module xnor_pop_bit_packer
  import xnor_pop_sequencer_pkg::*;
#(
  parameter int PACK_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cap_i,
  input  logic              bit_i,
  input  logic              emit_i,
  input  logic              last_i,
  input  logic              out_ready_i,
  output logic              full_o,
  output logic              fire_o,
  output logic [PACK_W-1:0] out_data_o,
  output logic              out_valid_o,
  output logic              out_last_o
);

  localparam int IW = clog2_min1(PACK_W);
  localparam logic [IW-1:0] IDX_LAST = IW'(PACK_W - 1);

  logic [PACK_W-1:0] pack_q, pack_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [PACK_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  assign full_o      = (idx_q == IDX_LAST);
  assign fire_o      = valid_q & out_ready_i;
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign out_last_o  = last_q;

  // Insert captured bit, latch a finished word, release on handshake.
  always_comb begin
    pack_d  = pack_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (cap_i) begin
      pack_d = pack_q | (PACK_W'(bit_i) << idx_q);
      if (idx_q != IDX_LAST) begin
        idx_d = idx_q + 1'b1;
      end
    end
    if (emit_i) begin
      valid_d = 1'b1;
      last_d  = last_i;
      data_d  = pack_d;
    end
    if (fire_o) begin
      valid_d = 1'b0;
      pack_d  = '0;
      idx_d   = '0;
    end
  end

  // Packer state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pack_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      pack_q  <= pack_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/xnor_pop_sequencer.sv
// Walks K weight/activation chunks per neuron, times the
// accumulator clear and packs threshold results into words.
module xnor_pop_sequencer
  import xnor_pop_sequencer_pkg::*;
#(
  parameter int K_CHUNKS  = 4,
  parameter int M_NEURONS = 32,
  parameter int PACK_W    = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  output logic busy,
  output logic done,
  xnor_pop_sequencer_if.master bus
);

  localparam int AAW = clog2_min1(K_CHUNKS);
  localparam int WAW = clog2_min1(M_NEURONS * K_CHUNKS);
  localparam int TAW = clog2_min1(M_NEURONS);
  localparam int DCW = clog2_min1(DRAIN_CYCLES);

  localparam logic [TAW-1:0] J_LAST = TAW'(M_NEURONS - 1);
  localparam logic [AAW-1:0] K_LAST = AAW'(K_CHUNKS - 1);
  localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN_CYCLES - 1);

  seq_state_e     state_q, state_d;
  logic [TAW-1:0] j_q, j_d;
  logic [AAW-1:0] k_q, k_d;
  logic [DCW-1:0] dc_q, dc_d;

  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           rd_en_q, rd_en_d;
  logic           acc_clr_q, acc_clr_d;
  logic [AAW-1:0] act_addr_q, act_addr_d;
  logic [WAW-1:0] wgt_addr_q, wgt_addr_d;
  logic [TAW-1:0] thr_addr_q, thr_addr_d;

  logic           cap;
  logic           emit;
  logic           fire;
  logic           word_full;
  logic           j_last;

  assign j_last = (j_q == J_LAST);

  assign busy         = busy_q;
  assign done         = done_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.acc_clr  = acc_clr_q;
  assign bus.act_addr = act_addr_q;
  assign bus.wgt_addr = wgt_addr_q;
  assign bus.thr_addr = thr_addr_q;

  xnor_pop_bit_packer #(
    .PACK_W (PACK_W)
  ) u_packer (
    .clk         (clk),
    .rstn        (rstn),
    .cap_i       (cap),
    .bit_i       (bus.cmp_in),
    .emit_i      (emit),
    .last_i      (j_last),
    .out_ready_i (bus.out_ready),
    .full_o      (word_full),
    .fire_o      (fire),
    .out_data_o  (bus.out_data),
    .out_valid_o (bus.out_valid),
    .out_last_o  (bus.out_last)
  );

  // Next state and neuron/chunk/drain counters.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    k_d     = k_q;
    dc_d    = dc_q;
    cap     = 1'b0;
    emit    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          j_d     = '0;
          k_d     = '0;
        end
      end
      S_RUN: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
          dc_d    = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (dc_q == D_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          dc_d = dc_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        cap = 1'b1;
        if (word_full || j_last) begin
          emit    = 1'b1;
          state_d = S_EMIT;
        end else begin
          j_d     = j_q + 1'b1;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_EMIT: begin
        if (fire) begin
          if (j_last) begin
            state_d = S_DONE;
          end else begin
            j_d     = j_q + 1'b1;
            k_d     = '0;
            state_d = S_RUN;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        j_d     = '0;
        k_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values decoded from the upcoming state.
  always_comb begin
    rd_en_d    = (state_d == S_RUN);
    acc_clr_d  = (state_d == S_RUN) && (k_d == '0);
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    act_addr_d = k_d;
    thr_addr_d = j_d;
    wgt_addr_d = WAW'(j_d) * WAW'(K_CHUNKS) + WAW'(k_d);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      j_q        <= '0;
      k_q        <= '0;
      dc_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      acc_clr_q  <= 1'b0;
      act_addr_q <= '0;
      wgt_addr_q <= '0;
      thr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      k_q        <= k_d;
      dc_q       <= dc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      acc_clr_q  <= acc_clr_d;
      act_addr_q <= act_addr_d;
      wgt_addr_q <= wgt_addr_d;
      thr_addr_q <= thr_addr_d;
    end
  end

endmodule

// File: tb/tb_xnor_pop_sequencer.sv
// Directed/random bench for xnor_pop_sequencer with a
// behavioural xnor-popcount datapath and memories.
module tb_xnor_pop_sequencer;

  localparam int K  = 4;
  localparam int M  = 32;
  localparam int MB = 20;
  localparam int PW = 16;

  logic clk;
  logic rstn;
  logic start_a, busy_a, done_a;
  logic start_b, busy_b, done_b;
  logic cmp_mode;

  int n_assert = 0;
  int n_fail   = 0;

  xnor_pop_sequencer_if #(.K_CHUNKS(K), .M_NEURONS(M), .PACK_W(PW)) bus_a ();
  xnor_pop_sequencer_if #(.K_CHUNKS(K), .M_NEURONS(MB), .PACK_W(PW)) bus_b ();

  xnor_pop_sequencer #(.K_CHUNKS(K), .M_NEURONS(M), .PACK_W(PW)) u_a (
    .clk   (clk),
    .rstn  (rstn),
    .start (start_a),
    .busy  (busy_a),
    .done  (done_a),
    .bus   (bus_a)
  );

  xnor_pop_sequencer #(.K_CHUNKS(K), .M_NEURONS(MB), .PACK_W(PW)) u_b (
    .clk   (clk),
    .rstn  (rstn),
    .start (start_b),
    .busy  (busy_b),
    .done  (done_b),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memories and datapath
  logic [7:0] act_m [K];
  logic [7:0] wgt_m [M*K];
  int         thr_m [M];
  logic [7:0] a_q, w_q;
  logic       v_q = 1'b0;
  int         sum_q = 0;

  function automatic int pc8(input logic [7:0] a, input logic [7:0] w);
    logic [7:0] x;
    x = ~(a ^ w);
    return $countones(x);
  endfunction

  always @(posedge clk) begin
    v_q <= bus_a.rd_en;
    if (bus_a.rd_en) begin
      a_q <= act_m[bus_a.act_addr];
      w_q <= wgt_m[bus_a.wgt_addr];
    end
    if (bus_a.acc_clr) sum_q <= 0;
    else if (v_q) sum_q <= sum_q + pc8(a_q, w_q);
  end

  assign bus_a.cmp_in = cmp_mode ? 1'b1 : (sum_q > thr_m[bus_a.thr_addr]);
  assign bus_b.cmp_in = bus_b.thr_addr[0];

  // Bench-side results
  logic [15:0] got_w[$];
  bit          got_l[$];
  int          j3_w[$];
  int          j3_a[$];
  int          j3_c[$];
  int          bcnt, dcnt;
  logic [15:0] exp_w [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < K; i++) act_m[i] = 8'($urandom);
    for (int i = 0; i < M*K; i++) wgt_m[i] = 8'($urandom);
    for (int i = 0; i < M; i++) thr_m[i] = $urandom_range(10, 22);
  endtask

  task automatic model_words();
    int s;
    exp_w[0] = '0;
    exp_w[1] = '0;
    for (int j = 0; j < M; j++) begin
      s = 0;
      for (int k = 0; k < K; k++) s += pc8(act_m[k], wgt_m[j*K + k]);
      if (s > thr_m[j]) exp_w[j / PW][j % PW] = 1'b1;
    end
  endtask

  task automatic run_a(input int stall, input bit poke);
    bit          fin;
    bit          stall_done;
    bit          resume_chk;
    int          resume_j;
    logic [15:0] hold_d;
    logic [6:0]  hold_wa;
    got_w.delete();
    got_l.delete();
    j3_w.delete();
    j3_a.delete();
    j3_c.delete();
    bcnt = 0;
    dcnt = 0;
    fin = 0;
    stall_done = (stall == 0);
    resume_chk = 0;
    resume_j = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int n = 0; n < 3000 && !fin; n++) begin
      if (n == 0) begin
        check("first_busy", busy_a, 1);
        check("first_rd_en", bus_a.rd_en, 1);
        check("first_acc_clr", bus_a.acc_clr, 1);
        check("first_wgt_addr", bus_a.wgt_addr, 0);
      end
      if (busy_a) bcnt++;
      if (done_a) begin
        dcnt++;
        fin = 1;
        check("busy_at_done", busy_a, 0);
      end
      if (resume_chk) begin
        resume_chk = 0;
        check("resume_rd_en", bus_a.rd_en, 1);
        check("resume_acc_clr", bus_a.acc_clr, 1);
        check("resume_thr_addr", bus_a.thr_addr, resume_j);
      end
      if (bus_a.rd_en && bus_a.thr_addr == 3) begin
        j3_w.push_back(int'(bus_a.wgt_addr));
        j3_a.push_back(int'(bus_a.act_addr));
        j3_c.push_back(int'(bus_a.acc_clr));
      end
      start_a = (poke && n == 40);
      if (bus_a.out_valid) begin
        if (!stall_done) begin
          stall_done = 1;
          hold_d = bus_a.out_data;
          hold_wa = bus_a.wgt_addr;
          resume_j = int'(bus_a.thr_addr) + 1;
          bus_a.out_ready = 1'b0;
          for (int s = 0; s < stall; s++) begin
            tick();
            if (busy_a) bcnt++;
            check("stall_valid", bus_a.out_valid, 1);
            check("stall_data", bus_a.out_data, hold_d);
            check("stall_rd_en", bus_a.rd_en, 0);
            check("stall_wgt_addr", bus_a.wgt_addr, hold_wa);
          end
          bus_a.out_ready = 1'b1;
          resume_chk = 1;
        end
        got_w.push_back(bus_a.out_data);
        got_l.push_back(bus_a.out_last);
      end
      if (!fin) tick();
    end
    start_a = 1'b0;
    if (!fin) check("pass_a_timeout", 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_a) dcnt++;
    end
  endtask

  task automatic check_words(input string tag);
    check({tag, "_nwords"}, got_w.size(), 2);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_word"}, (i < got_w.size()) ? got_w[i] : 16'hxxxx, exp_w[i]);
      check({tag, "_last"}, (i < got_l.size()) ? 32'(got_l[i]) : 32'hx, (i == 1) ? 1 : 0);
    end
  endtask

  initial begin
    bit found;
    bit fin;
    rstn = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    cmp_mode = 1'b1;
    randomize_mem();
    tick();
    tick();
    tick();
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_rd_en", bus_a.rd_en, 0);
    check("rst_acc_clr", bus_a.acc_clr, 0);
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_out_last", bus_a.out_last, 0);
    check("rst_out_data", bus_a.out_data, 0);
    check("rst_addrs", {bus_a.act_addr, bus_a.wgt_addr, bus_a.thr_addr}, 0);
    rstn = 1'b1;
    tick();

    // Pass 1: all results forced high, start poked while busy
    cmp_mode = 1'b1;
    exp_w[0] = 16'hFFFF;
    exp_w[1] = 16'hFFFF;
    run_a(0, 1);
    check_words("p1");
    check("p1_busy_cycles", bcnt, M*(K+3) + 2);
    check("p1_done_count", dcnt, 1);

    // Pass 2: random data through datapath, stall on word 0
    randomize_mem();
    model_words();
    cmp_mode = 1'b0;
    run_a(5, 0);
    check_words("p2");
    check("p2_busy_cycles", bcnt, M*(K+3) + 5 + 2);
    check("p2_done_count", dcnt, 1);
    check("j3_len", j3_w.size(), K);
    for (int i = 0; i < K; i++) begin
      check("j3_wgt_addr", (i < j3_w.size()) ? j3_w[i] : -1, 3*K + i);
      check("j3_act_addr", (i < j3_a.size()) ? j3_a[i] : -1, i);
      check("j3_acc_clr", (i < j3_c.size()) ? j3_c[i] : -1, (i == 0) ? 1 : 0);
    end

    // Pass 3: reset in the middle of neuron 9, then a clean pass
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    found = 0;
    for (int n = 0; n < 500 && !found; n++) begin
      if (bus_a.rd_en && bus_a.thr_addr == 9 && bus_a.act_addr == 1) found = 1;
      else tick();
    end
    check("reach_neuron9", found, 1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_done", done_a, 0);
    check("mid_rst_rd_en", bus_a.rd_en, 0);
    check("mid_rst_acc_clr", bus_a.acc_clr, 0);
    check("mid_rst_valid", bus_a.out_valid, 0);
    check("mid_rst_last", bus_a.out_last, 0);
    check("mid_rst_data", bus_a.out_data, 0);
    check("mid_rst_addrs", {bus_a.act_addr, bus_a.wgt_addr, bus_a.thr_addr}, 0);
    tick();
    check("post_rst_idle", busy_a, 0);
    randomize_mem();
    model_words();
    run_a(0, 0);
    check_words("p3");
    check("p3_done_count", dcnt, 1);

    // Pass 4: 20 neurons, odd neurons fire
    got_w.delete();
    got_l.delete();
    bcnt = 0;
    dcnt = 0;
    fin = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int n = 0; n < 2000 && !fin; n++) begin
      if (busy_b) bcnt++;
      if (done_b) begin
        dcnt++;
        fin = 1;
      end
      if (bus_b.out_valid) begin
        got_w.push_back(bus_b.out_data);
        got_l.push_back(bus_b.out_last);
      end
      if (!fin) tick();
    end
    if (!fin) check("pass_b_timeout", 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_b) dcnt++;
    end
    exp_w[0] = 16'hAAAA;
    exp_w[1] = 16'h000A;
    check_words("p4");
    check("p4_busy_cycles", bcnt, MB*(K+3) + 2);
    check("p4_done_count", dcnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
